// File: rtl/mips_register_file.sv
// 32 x 32 MIPS general-purpose register file: two combinational read ports plus a debug port,
// one synchronous write port, register 0 hardwired to zero, no internal write-through bypass.
module mips_rf_cell #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (we) q <= d;
  end
endmodule

module mips_register_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] DbgAddr,
  output logic [DATA_W-1:0] DbgData
);
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0]             we;

  // Entry 0 is a constant, so it reads zero even before the first reset.
  assign regs[0] = '0;
  assign we[0]   = 1'b0;

  genvar i;
  generate
    for (i = 1; i < NUM_REGS; i++) begin : g_reg
      assign we[i] = RegWrite && (WriteRegister == ADDR_W'(i));
      mips_rf_cell #(.DATA_W(DATA_W)) u_cell (
        .clk   (clk),
        .reset (reset),
        .we    (we[i]),
        .d     (WriteData),
        .q     (regs[i])
      );
    end
  endgenerate

  // Reads see stored state only; a same-cycle write shows up after the edge.
  assign ReadData1 = regs[rs];
  assign ReadData2 = regs[rt];
  assign DbgData   = regs[DbgAddr];
endmodule

// File: doc/mips_register_file.md
Name: mips_register_file

Overview:
- 32-entry x 32-bit general-purpose register file for the five-stage MIPS pipeline, sitting in the ID stage.
- Supplies ReadData1/ReadData2 to the WB-stage forwarding mux and the ID/EX pipeline register.
- Accepts the WB-stage writeback (WriteRegister, WriteData, RegWrite) on the rising clock edge.
- Does not bypass internally: same-cycle read-after-write is resolved by the downstream WB forwarding logic, so the read-during-write behaviour below is a hard contract.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- NUM_REGS, 32, number of architectural registers; must equal 2**ADDR_W

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high; clears all registers on the rising edge where asserted
- rs  input  ADDR_W  read address, port 1
- rt  input  ADDR_W  read address, port 2
- ReadData1  output  DATA_W  contents of register rs (combinational)
- ReadData2  output  DATA_W  contents of register rt (combinational)
- RegWrite  input  1  write enable from the WB stage
- WriteRegister  input  ADDR_W  write address from the WB stage
- WriteData  input  DATA_W  write data from the WB stage
- DbgAddr  input  ADDR_W  debug/testbench read address
- DbgData  output  DATA_W  contents of register DbgAddr (combinational)

Behaviour:
- Storage: NUM_REGS registers of DATA_W bits. Register 0 is hardwired to zero:
  - never written;
  - always reads 0 on every read port, including X-free after power-up before the first reset.
- Reset: the rising edge with reset=1 clears registers 1..31 to 0. reset has priority over a simultaneous write, so that write is discarded.
  - After reset, ReadData1 = ReadData2 = DbgData = 0 for all addresses.
  - Before the first reset, register contents are undefined except register 0.
- Write:
  - On the rising edge with reset=0, RegWrite=1 and WriteRegister!=0, the register at WriteRegister takes WriteData.
  - RegWrite=0, or WriteRegister=0, leaves all state unchanged.
  - Exactly one write per cycle; latency is 1 edge.
- Read:
  - ReadData1 = reg[rs], ReadData2 = reg[rt], DbgData = reg[DbgAddr]. All are purely combinational from address and stored state, with no clock latency.
  - rs == rt returns identical data on both ports.
- Read during write, same address: in the cycle where the write is presented, the read ports return the OLD value. The new value appears only after the rising edge. There is no write-through bypass; WB forwarding supplies the new value downstream. Verification must check the old value explicitly.
- Output changes: read outputs change only when an address changes or when the addressed register is updated at a clock edge.
- Reset mid-operation: a reset asserted during a stream of writes clears the file on that edge. Writes resume on the first edge with reset=0.
- No X propagation: reads of any written or reset register must be known values. Reads of register 0 are always 0 regardless of reset history.

Test Plan:
- Reset clear: write 0xDEADBEEF to r5, then assert reset for 1 cycle; rs=5, rt=31 give ReadData1=0 and ReadData2=0.
- Basic write/read: RegWrite=1, WriteRegister=8, WriteData=0x12345678, one edge; then rs=8 gives ReadData1=0x12345678, and rt=8 gives ReadData2=0x12345678.
- Zero register: RegWrite=1, WriteRegister=0, WriteData=0xFFFFFFFF, one edge; rs=0 gives ReadData1=0 and DbgData(DbgAddr=0)=0.
- Read-during-write: r9 holds 0x00000001. In one cycle apply rs=9 with a write of r9 := 0x00000002. Before the edge ReadData1=0x00000001; after the edge ReadData1=0x00000002.
- Write disabled plus reset priority:
  - RegWrite=0, WriteRegister=10, WriteData=0xAAAA5555: r10 keeps its prior value 0x0.
  - Same write with RegWrite=1 and reset=1 on that edge: r10=0.
- Full sweep: write reg[i] = i*0x01010101 for i=1..31 on consecutive edges, then read all via rs, rt and DbgAddr; every port matches, and reg[0]=0.
